// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM states, parity modes
// and a width helper for FIFO pointers and counters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-facing side of the UART receiver: head word, interrupt, pop handshake,
// occupancy and sticky error flags.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] uart_to_cpu_buf;
    logic                 read_int;
    logic                 cpu_end_read;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overrun;
    logic                 frame_err;
    logic                 parity_err;
    logic                 err_clr;

    modport master (
        input  uart_to_cpu_buf, read_int, fifo_count, overrun, frame_err, parity_err,
        output cpu_end_read, err_clr
    );

    modport slave (
        output uart_to_cpu_buf, read_int, fifo_count, overrun, frame_err, parity_err,
        input  cpu_end_read, err_clr
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with an always-visible head word. A push into a full FIFO
// is only taken when it coincides with a pop.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [clog2(DEPTH):0]    count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count/empty gate every read, so its power-up contents never leak out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a small FIFO, with CPU interrupt/pop
// handshake, sticky error flags and a CPU-written LED register.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_in,
    input  logic [LED_WIDTH-1:0] leds_array,
    input  logic                 write_leds,
    output logic [LED_WIDTH-1:0] leds,
    uart_rx_fifo_if.slave        cpu
);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = clog2(CLK_DIV);
    localparam int IDX_W = clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] HALF_BIT = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_BIT = DIV_W'(CLK_DIV - 1);
    localparam logic             PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_meta, rx_s, rx_prev;
    rx_state_t state, state_d;
    logic [DIV_W-1:0]     bit_cnt, cnt_d;
    logic [IDX_W-1:0]     bit_idx, idx_d;
    logic [DATA_BITS-1:0] shreg, sh_d;
    logic                 par_bad, pbad_d;
    logic                 push_req, frame_set, parity_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            rx_meta <= uart_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            state   <= state_d;
            bit_cnt <= cnt_d;
            bit_idx <= idx_d;
            shreg   <= sh_d;
            par_bad <= pbad_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = bit_cnt - 1'b1;
        idx_d      = bit_idx;
        sh_d       = shreg;
        pbad_d     = par_bad;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = bit_cnt;
                if (rx_prev && !rx_s) begin
                    cnt_d   = HALF_BIT;
                    state_d = START;
                end
            end
            START: if (bit_cnt == '0) begin
                cnt_d   = FULL_BIT;
                idx_d   = '0;
                pbad_d  = 1'b0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_cnt == '0) begin
                cnt_d = FULL_BIT;
                sh_d  = {rx_s, shreg[DATA_BITS-1:1]};
                idx_d = bit_idx + 1'b1;
                if (bit_idx == IDX_W'(DATA_BITS - 1))
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_cnt == '0) begin
                cnt_d   = FULL_BIT;
                pbad_d  = rx_s != ((^shreg) ^ PAR_MODE);
                state_d = STOP;
            end
            STOP: if (bit_cnt == '0) begin
                cnt_d   = '0;
                state_d = IDLE;
                if (!rx_s)        frame_set  = 1'b1;
                else if (par_bad) parity_set = 1'b1;
                else              push_req   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    logic                 cer_q, wl_q;
    logic                 pop_ok, push_ok, overrun_set, read_int_d;
    logic [DATA_BITS-1:0] head;
    logic [CNT_W-1:0]     count;
    logic                 full, empty;

    assign pop_ok      = cpu.cpu_end_read & ~cer_q & ~empty;
    assign push_ok     = push_req & (~full | pop_ok);
    assign overrun_set = push_req & full & ~pop_ok;
    // A new head appears either when the first word lands in an empty FIFO or when a pop exposes the next word.
    assign read_int_d  = (push_ok & empty) | (pop_ok & ((count > CNT_W'(1)) | push_ok));

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (shreg),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign cpu.uart_to_cpu_buf = empty ? '0 : head;
    assign cpu.fifo_count      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cer_q          <= 1'b0;
            wl_q           <= 1'b0;
            cpu.read_int   <= 1'b0;
            cpu.overrun    <= 1'b0;
            cpu.frame_err  <= 1'b0;
            cpu.parity_err <= 1'b0;
            leds           <= '0;
        end else begin
            cer_q          <= cpu.cpu_end_read;
            wl_q           <= write_leds;
            cpu.read_int   <= read_int_d;
            cpu.overrun    <= overrun_set | (cpu.overrun    & ~cpu.err_clr);
            cpu.frame_err  <= frame_set   | (cpu.frame_err  & ~cpu.err_clr);
            cpu.parity_err <= parity_set  | (cpu.parity_err & ~cpu.err_clr);
            if (write_leds && !wl_q) leds <= leds_array;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: an 8N1 instance and an 8O1 instance
// share clock, reset and LED inputs; a monitor checks every read_int head word.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_a = 1'b1;
    logic       uart_b = 1'b1;
    logic [7:0] leds_array = '0;
    logic       write_leds = 1'b0;
    logic [7:0] leds_a, leds_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) cpu_a ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) cpu_b ();

    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .FIFO_DEPTH(4), .LED_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .uart_in(uart_a), .leds_array(leds_array),
        .write_leds(write_leds), .leds(leds_a), .cpu(cpu_a.slave));

    uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .FIFO_DEPTH(4), .LED_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .uart_in(uart_b), .leds_array(leds_array),
        .write_leds(write_leds), .leds(leds_b), .cpu(cpu_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_a.read_int) begin
            if (exp_a.size() == 0) check("read_int_a_unexpected", 32'd1, 32'd0);
            else check("head_a", 32'(cpu_a.uart_to_cpu_buf), 32'(exp_a.pop_front()));
        end
        if (cpu_b.read_int) begin
            if (exp_b.size() == 0) check("read_int_b_unexpected", 32'd1, 32'd0);
            else check("head_b", 32'(cpu_b.uart_to_cpu_buf), 32'(exp_b.pop_front()));
        end
    end

    task automatic drive_line(input bit sel_b, input logic v);
        if (sel_b) uart_b = v;
        else       uart_a = v;
    endtask

    task automatic wait_bit();
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel_b, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        drive_line(sel_b, 1'b0);
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            drive_line(sel_b, data[i]);
            wait_bit();
        end
        if (has_par) begin
            drive_line(sel_b, par_bit);
            wait_bit();
        end
        drive_line(sel_b, stop_bit);
        wait_bit();
        drive_line(sel_b, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_a();
        cpu_a.cpu_end_read = 1'b1;
        repeat (3) @(negedge clk);
        cpu_a.cpu_end_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;
        cpu_a.cpu_end_read = 1'b0;
        cpu_a.err_clr      = 1'b0;
        cpu_b.cpu_end_read = 1'b0;
        cpu_b.err_clr      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_buf", 32'(cpu_a.uart_to_cpu_buf), 32'h0);
        check("rst_count", 32'(cpu_a.fifo_count), 32'd0);
        check("rst_read_int", 32'(cpu_a.read_int), 32'd0);
        check("rst_flags", 32'({cpu_a.overrun, cpu_a.frame_err, cpu_a.parity_err}), 32'd0);
        check("rst_leds", 32'(leds_a), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single 8N1 frame, then pop it.
        exp_a.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_count", 32'(cpu_a.fifo_count), 32'd1);
        check("a5_buf", 32'(cpu_a.uart_to_cpu_buf), 32'hA5);
        check("a5_flags", 32'({cpu_a.overrun, cpu_a.frame_err, cpu_a.parity_err}), 32'd0);
        pop_a();
        check("a5_pop_count", 32'(cpu_a.fifo_count), 32'd0);
        check("a5_pop_buf", 32'(cpu_a.uart_to_cpu_buf), 32'h0);

        // Short low glitch must be rejected silently.
        uart_a = 1'b0;
        repeat (5) @(negedge clk);
        uart_a = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_count", 32'(cpu_a.fifo_count), 32'd0);
        check("glitch_flags", 32'({cpu_a.overrun, cpu_a.frame_err, cpu_a.parity_err}), 32'd0);

        // Broken stop bit, then clear.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("ferr_set", 32'(cpu_a.frame_err), 32'd1);
        check("ferr_count", 32'(cpu_a.fifo_count), 32'd0);
        cpu_a.err_clr = 1'b1;
        @(negedge clk);
        cpu_a.err_clr = 1'b0;
        @(negedge clk);
        check("ferr_clr", 32'(cpu_a.frame_err), 32'd0);

        // Five frames into a four-deep FIFO.
        exp_a.push_back(8'h01);
        for (int i = 1; i <= 5; i++) begin
            w = 8'(i);
            send_frame(1'b0, w, 1'b0, 1'b0, 1'b1);
        end
        check("ovr_flag", 32'(cpu_a.overrun), 32'd1);
        check("ovr_count", 32'(cpu_a.fifo_count), 32'd4);
        check("ovr_buf", 32'(cpu_a.uart_to_cpu_buf), 32'h01);
        for (int i = 2; i <= 4; i++) begin
            w = 8'(i);
            exp_a.push_back(w);
            pop_a();
            check("drain_buf", 32'(cpu_a.uart_to_cpu_buf), 32'(w));
            check("drain_count", 32'(cpu_a.fifo_count), 32'(5 - i));
        end
        pop_a();
        check("drain_empty_count", 32'(cpu_a.fifo_count), 32'd0);
        check("drain_empty_buf", 32'(cpu_a.uart_to_cpu_buf), 32'h0);

        // Odd parity: 0x07 has three ones, so the parity bit must be 0.
        exp_b.push_back(8'h07);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("par_ok_count", 32'(cpu_b.fifo_count), 32'd1);
        check("par_ok_buf", 32'(cpu_b.uart_to_cpu_buf), 32'h07);
        check("par_ok_flag", 32'(cpu_b.parity_err), 32'd0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("par_bad_flag", 32'(cpu_b.parity_err), 32'd1);
        check("par_bad_count", 32'(cpu_b.fifo_count), 32'd1);

        // LED register load.
        leds_array = 8'h5A;
        write_leds = 1'b1;
        @(negedge clk);
        check("leds_load", 32'(leds_a), 32'h5A);
        write_leds = 1'b0;
        leds_array = 8'h00;
        @(negedge clk);
        check("leds_hold", 32'(leds_a), 32'h5A);

        // Leave a word in the FIFO, then reset in the middle of a frame.
        exp_a.push_back(8'h11);
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", 32'(cpu_a.fifo_count), 32'd1);
        uart_a = 1'b0;
        wait_bit();
        uart_a = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_leds", 32'(leds_a), 32'h0);
        check("mid_rst_count", 32'(cpu_a.fifo_count), 32'd0);
        check("mid_rst_flags", 32'({cpu_a.overrun, cpu_a.frame_err, cpu_a.parity_err}), 32'd0);
        check("mid_rst_count_b", 32'(cpu_b.fifo_count), 32'd0);
        uart_a = 1'b1;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);

        exp_a.push_back(8'hC3);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        check("c3_count", 32'(cpu_a.fifo_count), 32'd1);
        check("c3_buf", 32'(cpu_a.uart_to_cpu_buf), 32'hC3);
        check("c3_flags", 32'({cpu_a.overrun, cpu_a.frame_err, cpu_a.parity_err}), 32'd0);

        repeat (4) @(negedge clk);
        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable, parametrised UART receiver for the CPU-facing serial port, clocked by a single system clock.
- Oversamples uart_in, assembles DATA_BITS-wide frames with optional parity, and queues them in a FIFO_DEPTH-entry FIFO.
- Presents the FIFO head to the CPU with an interrupt pulse and a cpu_end_read pop handshake, and reports sticky overrun/frame/parity errors.
- Keeps the CPU-written LED register.

Parameters:
- CLK_DIV, 16, clock cycles per bit; even, >=4.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, >=2.
- LED_WIDTH, 8, LED register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- uart_in  in  1  serial line; asynchronous; idles high.
- uart_to_cpu_buf  out  DATA_BITS  FIFO head word; 0 when the FIFO is empty.
- read_int  out  1  one-cycle pulse: a new word is visible on uart_to_cpu_buf.
- cpu_end_read  in  1  CPU done with the head word; rising edge pops; synchronous to clk.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words held.
- overrun  out  1  sticky: a frame arrived while the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled 0.
- parity_err  out  1  sticky: parity mismatch.
- err_clr  in  1  high for one cycle clears all three sticky flags.
- leds_array  in  LED_WIDTH  LED data from the CPU.
- write_leds  in  1  rising edge loads leds_array into leds; synchronous.
- leds  out  LED_WIDTH  LED register.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0; synchroniser flops are set to 1.
  - A reset mid-frame discards the partial frame.
- uart_in passes through a 2-flop synchroniser (rx_s); all sampling uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge of rx_s loads bit_cnt = CLK_DIV/2-1 and moves to START.
  - START: when bit_cnt reaches 0, sample (mid start bit).
    - rx_s=0: reload CLK_DIV-1 and go to DATA.
    - rx_s=1: glitch; return to IDLE with no flag.
  - DATA: sample every CLK_DIV cycles, LSB first, into the shift register. After DATA_BITS samples, go to PARITY if PARITY_EN, otherwise STOP.
  - PARITY: one sample compared with the XOR of the data bits (inverted when PARITY_ODD). A mismatch is latched for this frame.
  - STOP: one sample, then return to IDLE in the same cycle.
    - rx_s=0: set frame_err; drop the word.
    - rx_s=1 with a parity mismatch: set parity_err; drop the word.
    - rx_s=1, parity OK: push the word.
    - Push when full: set overrun, drop the new word, keep the FIFO contents.
- A new falling edge is accepted in the cycle after the return to IDLE. Back-to-back frames with 1 stop bit are supported.
- Latency: the push is written on the clock edge after the stop-bit sample.
  - If the FIFO was empty, read_int is high for the cycle following that edge and uart_to_cpu_buf already holds the word.
- Pop: cpu_end_read is registered; a pop occurs on cycles where cpu_end_read=1 and its registered value is 0.
  - Pop on empty is ignored.
  - After a pop that leaves the FIFO non-empty, read_int pulses one cycle later with the new head visible.
  - Holding cpu_end_read high gives a single pop.
- Simultaneous push and pop:
  - fifo_count is unchanged; pointers advance.
  - read_int pulses once, for the pop's new head.
  - Push into a full FIFO is accepted when it coincides with a pop; overrun is not set.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty come from fifo_count.
- Error flags: set has priority over err_clr in the same cycle.
- LEDs: a write_leds rising edge (registered edge detect) loads leds_array; leds is updated in the cycle after the edge.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants.
  - Function clog2 for pointer/count widths.
- One sub-module: sync_fifo (WIDTH, DEPTH; push, pop, head, count, full, empty; async active-low reset). The FSM, synchroniser, interrupt and LED logic stay in uart_rx_fifo.

Test Plan:
- CLK_DIV=16, send 0xA5 (8N1) -> read_int pulses exactly once; uart_to_cpu_buf=0xA5; fifo_count=1; no error flags. Pop -> fifo_count=0; buf=0x00; no read_int.
- Low glitch of 5 clocks on uart_in -> FSM returns to IDLE; fifo_count=0; no flags set.
- Send 0x3C with the stop bit forced 0 -> frame_err=1; fifo_count=0. err_clr pulse -> frame_err=0.
- Send 0x01,0x02,0x03,0x04,0x05 without popping (depth 4) -> overrun=1; fifo_count=4; buf=0x01. Four pops -> buf reads 0x02,0x03,0x04 (each with a read_int pulse), then the FIFO is empty.
- PARITY_EN=1, PARITY_ODD=1: send 0x07 with parity bit 0 -> pushed. Send 0x07 with parity bit 1 -> parity_err=1; word dropped.
- write_leds rising edge with leds_array=0x5A -> leds=0x5A next cycle. rst_n low mid-DATA -> leds=0, fifo_count=0, flags 0. Next clean frame 0xC3 is received correctly.
